// File: rtl/neuron_mac_lanes.sv
// neuron_mac_lanes: LANES-wide MAC neuron with a run-time loaded weight RAM, bias and activation; NEURON_MAC_SAT_EN selects saturating accumulation.
module neuron_mac_lanes #(
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0,
  parameter int NUM_WEIGHT = 784,
  parameter int DATA_WIDTH = 16,
  parameter int INT_WIDTH  = 1,
  parameter int LANES      = 4,
  parameter int ACT_RELU   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        w_valid,
  input  logic [DATA_WIDTH-1:0]       w_data,
  input  logic                        b_valid,
  input  logic [DATA_WIDTH-1:0]       b_data,
  input  logic [31:0]                 cfg_layer,
  input  logic [31:0]                 cfg_neuron,
  output logic                        w_drop,
  output logic [DATA_WIDTH-1:0]       out,
  output logic                        out_valid,
  input  logic                        out_ready
);
  localparam int DW    = DATA_WIDTH;
  localparam int FRAC  = DW - 1 - INT_WIDTH;
  localparam int AW    = 2 * DW;
  localparam int LB    = $clog2(LANES);
  localparam int TW    = AW + LB;
  localparam int SW    = TW + 1;
  localparam int BEATS = NUM_WEIGHT / LANES;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int RW    = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int KW    = LANES > 1 ? LB : 1;
  localparam int PW    = NUM_WEIGHT > 1 ? $clog2(NUM_WEIGHT) : 1;
  typedef enum logic [2:0] {RUN, DRAIN, BIAS, ACT, OUT} state_t;
  state_t state, state_n;
  logic [BW-1:0] beat_cnt;
  logic [PW-1:0] w_ptr;
  logic v0, v1, v2;
  logic signed [AW-1:0] acc, sh;
  logic signed [DW-1:0] bias, act;
  logic signed [DW-1:0] x_r [LANES];
  logic signed [DW-1:0] w_r [LANES];
  logic signed [AW-1:0] prod [LANES];
  logic signed [TW-1:0] tree_c, tree;
  logic [DW-1:0] ram [LANES][BEATS];
  logic match, go, idle, w_en;
  assign match = cfg_layer == 32'(LAYER_NO) && cfg_neuron == 32'(NEURON_NO);
  assign go    = in_valid && in_ready;
  assign idle  = state == RUN && beat_cnt == '0 && !(v0 || v1 || v2);
  assign w_en  = match && w_valid && idle;
  function automatic logic signed [AW-1:0] acc_add(input logic signed [AW-1:0] a, input logic signed [TW-1:0] b);
`ifdef NEURON_MAC_SAT_EN
    logic signed [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return (s[SW-1:AW-1] == '0 || &s[SW-1:AW-1]) ? s[AW-1:0] : {s[SW-1], {(AW-1){~s[SW-1]}}};
`else
    return AW'(a + b);
`endif
  endfunction
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RUN;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      RUN:     state_n = go && beat_cnt == BW'(BEATS - 1) ? DRAIN : RUN;
      DRAIN:   state_n = !v0 && !v1 ? BIAS : DRAIN;
      BIAS:    state_n = ACT;
      ACT:     state_n = OUT;
      OUT:     state_n = out_ready ? RUN : OUT;
      default: state_n = RUN;
    endcase
  end
  always_comb in_ready = state == RUN && beat_cnt < BW'(BEATS);
  always_comb begin
    tree_c = '0;
    for (int i = 0; i < LANES; i++) tree_c = tree_c + TW'(prod[i]);
  end
  always_comb begin
    sh  = acc >>> FRAC;
    act = (&sh[AW-1:DW-1] || ~|sh[AW-1:DW-1]) ? sh[DW-1:0] : {sh[AW-1], {(DW-1){~sh[AW-1]}}};
    act = (ACT_RELU != 0 && acc[AW-1]) ? '0 : act;
  end
  // Weight RAM and datapath registers carry no reset: contents survive reset and the valids gate them.
  always_ff @(posedge clk) begin
    if (w_en) ram[KW'(w_ptr % LANES)][RW'(w_ptr / LANES)] <= w_data;
    for (int i = 0; i < LANES; i++) begin
      if (go) begin
        w_r[i] <= ram[i][beat_cnt[RW-1:0]];
        x_r[i] <= in_data[i*DW +: DW];
      end
      if (v0) prod[i] <= AW'(x_r[i]) * AW'(w_r[i]);
    end
    if (v1) tree <= tree_c;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      w_drop    <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      bias      <= '0;
      w_ptr     <= '0;
      acc       <= '0;
      beat_cnt  <= '0;
    end else begin
      v0        <= go;
      v1        <= v0;
      v2        <= v1;
      w_drop    <= match && w_valid && !idle;
      out_valid <= state_n == OUT;
      if (b_valid && match) bias <= b_data;
      if (w_en) w_ptr <= w_ptr == PW'(NUM_WEIGHT - 1) ? '0 : w_ptr + 1'b1;
      if (state == OUT && out_ready) begin
        acc      <= '0;
        beat_cnt <= '0;
      end else begin
        if (go) beat_cnt <= beat_cnt + 1'b1;
        if (state == BIAS) acc <= acc_add(acc, TW'(bias) <<< FRAC);
        else if (v2) acc <= acc_add(acc, tree);
      end
      if (state == ACT) out <= act;
    end
endmodule

// File: tb/tb_neuron_mac_lanes.sv
// tb_neuron_mac_lanes: scoreboard bench for neuron_mac_lanes with a ReLU and an identity instance fed identically.
module tb_neuron_mac_lanes;
  logic clk = 1'b0;
  logic rst;
  logic [63:0] in_data;
  logic in_valid, w_valid, b_valid, out_ready;
  logic [15:0] w_data, b_data;
  logic [31:0] cfg_layer, cfg_neuron;
  logic r_in_ready, r_w_drop, r_valid, i_in_ready, i_w_drop, i_valid;
  logic [15:0] r_out, i_out;
  logic [15:0] q_r[$], q_i[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  neuron_mac_lanes #(.LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(8), .DATA_WIDTH(16),
    .INT_WIDTH(1), .LANES(4), .ACT_RELU(1)) u_relu (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(r_in_ready),
    .w_valid(w_valid), .w_data(w_data), .b_valid(b_valid), .b_data(b_data),
    .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron), .w_drop(r_w_drop),
    .out(r_out), .out_valid(r_valid), .out_ready(out_ready));

  neuron_mac_lanes #(.LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(8), .DATA_WIDTH(16),
    .INT_WIDTH(1), .LANES(4), .ACT_RELU(0)) u_id (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(i_in_ready),
    .w_valid(w_valid), .w_data(w_data), .b_valid(b_valid), .b_data(b_data),
    .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron), .w_drop(i_w_drop),
    .out(i_out), .out_valid(i_valid), .out_ready(out_ready));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  always @(negedge clk)
    if (rst && out_ready) begin
      if (r_valid) begin
        if (q_r.size() == 0) chk("relu_spurious_out", 32'(r_out), 32'hDEAD);
        else chk("relu_out", 32'(r_out), 32'(q_r.pop_front()));
      end
      if (i_valid) begin
        if (q_i.size() == 0) chk("id_spurious_out", 32'(i_out), 32'hDEAD);
        else chk("id_out", 32'(i_out), 32'(q_i.pop_front()));
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] x);
    int n = 0;
    in_data  = {4{x}};
    in_valid = 1'b1;
    while (!r_in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'(r_in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!r_valid && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("out_valid_timeout", 32'(r_valid), 32'd1);
    tick();
  endtask

  task automatic load_w(input logic [15:0] v);
    for (int k = 0; k < 8; k++) begin
      w_valid = 1'b1;
      w_data  = v;
      tick();
    end
    w_valid = 1'b0;
  endtask

  task automatic set_bias(input logic [15:0] v);
    b_valid = 1'b1;
    b_data  = v;
    tick();
    b_valid = 1'b0;
  endtask

  task automatic vec(input logic [15:0] x, input logic [15:0] er, input logic [15:0] ei);
    q_r.push_back(er);
    q_i.push_back(ei);
    beat(x);
    beat(x);
    wait_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; w_valid = 1'b0; w_data = '0;
    b_valid = 1'b0; b_data = '0; cfg_layer = 32'd1; cfg_neuron = 32'd0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", 32'(r_in_ready), 32'd1);
    chk("rst_out_valid", 32'(r_valid), 32'd0);
    chk("rst_out", 32'(r_out), 32'd0);
    chk("rst_w_drop", 32'(r_w_drop), 32'd0);
    rst = 1'b1;
    tick();
    // basic sum with latency: 8 * 0.125 * 1.0 - 0.5 = 0.5
    load_w(16'h0800);
    set_bias(16'hE000);
    q_r.push_back(16'h2000);
    q_i.push_back(16'h2000);
    beat(16'h4000);
    beat(16'h4000);
    repeat (4) tick();
    chk("lat_e4_valid", 32'(r_valid), 32'd0);
    chk("drain_in_ready", 32'(r_in_ready), 32'd0);
    tick();
    chk("lat_e5_valid", 32'(r_valid), 32'd1);
    wait_out();
    // output saturation: 8 * 0.25 = 2.0
    load_w(16'h1000);
    set_bias(16'h0000);
    vec(16'h4000, 16'h7FFF, 16'h7FFF);
    // negative result: 1.0 - 1.5 = -0.5
    load_w(16'h0800);
    set_bias(16'hA000);
    vec(16'h4000, 16'h0000, 16'hE000);
    // accumulator overflow
    load_w(16'h7FFF);
    set_bias(16'h0000);
`ifdef NEURON_MAC_SAT_EN
    vec(16'h7FFF, 16'h7FFF, 16'h7FFF);
`else
    vec(16'h7FFF, 16'h0000, 16'hFFE0);
`endif
    // backpressure
    load_w(16'h0800);
    set_bias(16'hE000);
    out_ready = 1'b0;
    q_r.push_back(16'h2000);
    q_i.push_back(16'h2000);
    beat(16'h4000);
    beat(16'h4000);
    for (int n = 0; n < 40 && !r_valid; n++) tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_out", 32'(r_out), 32'h2000);
      chk("bp_valid", 32'(r_valid), 32'd1);
      chk("bp_in_ready", 32'(r_in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(r_valid), 32'd0);
    chk("bp_release_in_ready", 32'(r_in_ready), 32'd1);
    // matched weight write mid-vector is dropped
    q_r.push_back(16'h2000);
    q_i.push_back(16'h2000);
    beat(16'h4000);
    w_valid = 1'b1;
    w_data  = 16'h7FFF;
    tick();
    w_valid = 1'b0;
    chk("w_drop_pulse", 32'(r_w_drop), 32'd1);
    tick();
    chk("w_drop_clear", 32'(r_w_drop), 32'd0);
    beat(16'h4000);
    wait_out();
    // non-matching write while idle: no write, no drop
    cfg_neuron = 32'd1;
    w_valid = 1'b1;
    w_data  = 16'h7FFF;
    tick();
    w_valid = 1'b0;
    chk("nomatch_w_drop", 32'(r_w_drop), 32'd0);
    cfg_neuron = 32'd0;
    vec(16'h4000, 16'h2000, 16'h2000);
    // reset mid-vector aborts; weights survive, bias clears to 0 -> 1.0
    beat(16'h4000);
    rst = 1'b0;
    #2;
    chk("midrst_out_valid", 32'(r_valid), 32'd0);
    chk("midrst_in_ready", 32'(r_in_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    vec(16'h4000, 16'h4000, 16'h4000);
    set_bias(16'hE000);
    vec(16'h4000, 16'h2000, 16'h2000);
    repeat (3) tick();
    chk("relu_queue_empty", 32'(q_r.size()), 32'd0);
    chk("id_queue_empty", 32'(q_i.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
